// File: rtl/display_mux.sv
// display_mux
// Time-multiplexed 7-segment driver for DIGITS digits. A prescaler divides CLK
// down to one digit slot every SCAN_DIV cycles and a digit index walks 0..DIGITS-1.
// New display data is staged on LOAD. It is copied into the displayed (shadow)
// copy only at the end of a full frame, or at once while scanning is stopped,
// so a frame is never drawn with half old and half new digits.
//
// Ports
//   CLK    : clock, rising edge
//   RST    : asynchronous reset, active low
//   EN     : scan enable; while low the scan holds at digit 0 and outputs go dark
//   LOAD   : one-cycle strobe that captures VALUE, DP and LZ
//   VALUE  : 4 bits per digit, nibble i drives digit i (digit 0 least significant)
//   DP     : decimal point per digit
//   LZ     : leading-zero suppression enable
//   DISP   : segments a..g on DISP[6]..DISP[0], registered
//   DP_OUT : decimal-point segment, registered
//   AN     : one-hot digit select, registered
module display_mux #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int HEX_MODE       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] VALUE,
    input  logic [DIGITS-1:0]   DP,
    input  logic                LZ,
    output logic [6:0]          DISP,
    output logic                DP_OUT,
    output logic [DIGITS-1:0]   AN
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PRE_W-1:0]    prescaler_q, prescaler_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] stage_value_q, stage_value_d;
    logic [DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic                stage_lz_q, stage_lz_d;
    logic [4*DIGITS-1:0] shadow_value_q, shadow_value_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                shadow_lz_q, shadow_lz_d;
    logic                pending_q, pending_d;
    logic [6:0]          disp_q, disp_d;
    logic                dp_out_q, dp_out_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                tick;
    logic                wrap;
    logic                commit;
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic                cur_blank;
    logic                zero_run;
    logic [6:0]          seg_raw;

    assign tick   = EN && (prescaler_q == PRE_MAX);
    assign wrap   = tick && (idx_q == IDX_MAX);
    // The shadow copy may only change at a frame boundary, or at any time while
    // nothing is being scanned out.
    assign commit = !EN || wrap;

    always_comb begin
        prescaler_d = prescaler_q;
        idx_d       = idx_q;
        if (!EN) begin
            prescaler_d = '0;
            idx_d       = '0;
        end else if (tick) begin
            prescaler_d = '0;
            idx_d       = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end else begin
            prescaler_d = prescaler_q + PRE_W'(1);
        end
    end

    // A load landing on a commit edge goes straight through to the shadow copy;
    // otherwise it waits in staging, and later loads simply overwrite it.
    always_comb begin
        stage_value_d  = stage_value_q;
        stage_dp_d     = stage_dp_q;
        stage_lz_d     = stage_lz_q;
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_lz_d    = shadow_lz_q;
        pending_d      = pending_q;
        if (LOAD) begin
            stage_value_d = VALUE;
            stage_dp_d    = DP;
            stage_lz_d    = LZ;
            if (commit) begin
                shadow_value_d = VALUE;
                shadow_dp_d    = DP;
                shadow_lz_d    = LZ;
                pending_d      = 1'b0;
            end else begin
                pending_d      = 1'b1;
            end
        end else if (commit && pending_q) begin
            shadow_value_d = stage_value_q;
            shadow_dp_d    = stage_dp_q;
            shadow_lz_d    = stage_lz_q;
            pending_d      = 1'b0;
        end
    end

    // Walk from the most significant digit down so zero_run tells whether this
    // digit and every digit above it are zero.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow_value_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = shadow_value_q[4*i +: 4];
                cur_dp     = shadow_dp_q[i];
                cur_blank  = shadow_lz_q && zero_run && (i != 0);
            end
        end
    end

    always_comb begin
        seg_raw = 7'b0000000;
        case (cur_nibble)
            4'h0: seg_raw = 7'b1111110;
            4'h1: seg_raw = 7'b0110000;
            4'h2: seg_raw = 7'b1101101;
            4'h3: seg_raw = 7'b1111001;
            4'h4: seg_raw = 7'b0110011;
            4'h5: seg_raw = 7'b1011011;
            4'h6: seg_raw = 7'b1011111;
            4'h7: seg_raw = 7'b1110000;
            4'h8: seg_raw = 7'b1111111;
            4'h9: seg_raw = 7'b1111011;
            4'hA: seg_raw = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
            4'hB: seg_raw = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
            4'hC: seg_raw = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
            4'hD: seg_raw = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
            4'hE: seg_raw = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
            default: seg_raw = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
        endcase
    end

    // Outputs are built from the index before it advances, which gives the
    // one-cycle lag behind the scan; with scanning stopped everything goes dark.
    always_comb begin
        disp_d   = 7'b0000000;
        dp_out_d = 1'b0;
        an_d     = '0;
        if (EN) begin
            disp_d   = cur_blank ? 7'b0000000 : seg_raw;
            dp_out_d = cur_dp;
            for (int i = 0; i < DIGITS; i++) begin
                an_d[i] = (idx_q == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescaler_q    <= '0;
            idx_q          <= '0;
            stage_value_q  <= '0;
            stage_dp_q     <= '0;
            stage_lz_q     <= 1'b0;
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            shadow_lz_q    <= 1'b0;
            pending_q      <= 1'b0;
            disp_q         <= 7'b0000000;
            dp_out_q       <= 1'b0;
            an_q           <= '0;
        end else begin
            prescaler_q    <= prescaler_d;
            idx_q          <= idx_d;
            stage_value_q  <= stage_value_d;
            stage_dp_q     <= stage_dp_d;
            stage_lz_q     <= stage_lz_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_lz_q    <= shadow_lz_d;
            pending_q      <= pending_d;
            disp_q         <= disp_d;
            dp_out_q       <= dp_out_d;
            an_q           <= an_d;
        end
    end

    // Polarity is a pure XOR on the registered values, so it adds no delay.
    assign DISP   = disp_q ^ SEG_INV;
    assign DP_OUT = dp_out_q ^ DP_INV;
    assign AN     = an_q ^ AN_INV;

endmodule

// File: tb/tb_display_mux.sv
// Testbench for display_mux. Two instances share one stimulus stream: dut_a is
// hex mode with active-high outputs, dut_b is decimal-only with both output
// groups active low. A frame-time model predicts the active-high outputs and
// a compare process checks both instances against it on every falling edge.
module tb_display_mux;

    localparam int DIG   = 4;
    localparam int SCAN  = 4;
    localparam int FRAME = DIG * SCAN;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [6:0]  disp_a, disp_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;
    logic [15:0] rnd_value;

    logic [3:0] lit_an   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [6:0] lit_scan [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};

    display_mux #(
        .DIGITS(DIG), .SCAN_DIV(SCAN), .HEX_MODE(1),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut_a (
        .CLK(clk), .RST(rst_n), .EN(en), .LOAD(load), .VALUE(value), .DP(dp),
        .LZ(lz), .DISP(disp_a), .DP_OUT(dp_a), .AN(an_a)
    );

    display_mux #(
        .DIGITS(DIG), .SCAN_DIV(SCAN), .HEX_MODE(0),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_b (
        .CLK(clk), .RST(rst_n), .EN(en), .LOAD(load), .VALUE(value), .DP(dp),
        .LZ(lz), .DISP(disp_b), .DP_OUT(dp_b), .AN(an_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment images straight from the character table.
    function automatic logic [6:0] seg_code(input logic [3:0] nib, input bit hex);
        case (nib)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return hex ? 7'b1110111 : 7'b0000000;
            4'hB: return hex ? 7'b0011111 : 7'b0000000;
            4'hC: return hex ? 7'b1001110 : 7'b0000000;
            4'hD: return hex ? 7'b0111101 : 7'b0000000;
            4'hE: return hex ? 7'b1001111 : 7'b0000000;
            default: return hex ? 7'b1000111 : 7'b0000000;
        endcase
    endfunction

    // A digit is blank when the number shifted down to it is zero (leading zero).
    function automatic logic [6:0] digit_image(input logic [15:0] v, input logic sup,
                                               input int d, input bit hex);
        logic [15:0] upper;
        upper = v >> (4 * d);
        if (sup && d > 0 && upper == 16'h0000) return 7'b0000000;
        return seg_code(upper[3:0], hex);
    endfunction

    // Model: m_t counts clock edges since scanning (re)started; the slot and the
    // frame boundaries follow from plain division of that count.
    int          m_t;
    logic [1:0]  m_slot;
    logic        m_apply;
    logic [15:0] m_stage_v, m_shadow_v;
    logic [3:0]  m_stage_dp, m_shadow_dp;
    logic        m_stage_lz, m_shadow_lz, m_pending;
    logic [6:0]  exp_disp_hex, exp_disp_dec;
    logic        exp_dp;
    logic [3:0]  exp_an;

    assign m_slot  = 2'((m_t / SCAN) % DIG);
    assign m_apply = !en || ((m_t + 1) % FRAME == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0;
            m_stage_v <= '0; m_stage_dp <= '0; m_stage_lz <= 1'b0;
            m_shadow_v <= '0; m_shadow_dp <= '0; m_shadow_lz <= 1'b0;
            m_pending <= 1'b0;
            exp_disp_hex <= '0; exp_disp_dec <= '0; exp_dp <= 1'b0; exp_an <= '0;
        end else begin
            if (load) begin
                m_stage_v <= value; m_stage_dp <= dp; m_stage_lz <= lz;
                if (m_apply) begin
                    m_shadow_v <= value; m_shadow_dp <= dp; m_shadow_lz <= lz;
                    m_pending <= 1'b0;
                end else begin
                    m_pending <= 1'b1;
                end
            end else if (m_apply && m_pending) begin
                m_shadow_v <= m_stage_v; m_shadow_dp <= m_stage_dp; m_shadow_lz <= m_stage_lz;
                m_pending <= 1'b0;
            end
            m_t <= en ? m_t + 1 : 0;
            if (en) begin
                exp_an       <= 4'b0001 << m_slot;
                exp_dp       <= m_shadow_dp[m_slot];
                exp_disp_hex <= digit_image(m_shadow_v, m_shadow_lz, int'(m_slot), 1'b1);
                exp_disp_dec <= digit_image(m_shadow_v, m_shadow_lz, int'(m_slot), 1'b0);
            end else begin
                exp_an <= '0; exp_dp <= 1'b0; exp_disp_hex <= '0; exp_disp_dec <= '0;
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // dut_b drives inverted levels, so its expectation is the model XOR all-ones.
    always @(negedge clk) begin
        if (cmp_on) begin
            check_output("cmp_disp_a", {1'b0, disp_a}, {1'b0, exp_disp_hex});
            check_output("cmp_dp_a",   {7'b0, dp_a},   {7'b0, exp_dp});
            check_output("cmp_an_a",   {4'b0, an_a},   {4'b0, exp_an});
            check_output("cmp_disp_b", {1'b0, disp_b}, {1'b0, exp_disp_dec ^ 7'h7F});
            check_output("cmp_dp_b",   {7'b0, dp_b},   {7'b0, ~exp_dp});
            check_output("cmp_an_b",   {4'b0, an_b},   {4'b0, exp_an ^ 4'hF});
        end
    end

    // One clock of stimulus: drive on the falling edge, return just after the
    // rising edge that sampled it.
    task automatic apply_stimulus(input logic s_en, input logic s_load,
                                  input logic [15:0] s_value, input logic [3:0] s_dp,
                                  input logic s_lz);
        @(negedge clk);
        en = s_en; load = s_load; value = s_value; dp = s_dp; lz = s_lz;
        @(posedge clk);
        #2;
    endtask

    task automatic run_idle(input int n);
        repeat (n) apply_stimulus(1'b1, 1'b0, value, dp, lz);
    endtask

    task automatic check_inactive(input string tag);
        check_output({tag, "_disp_a"}, {1'b0, disp_a}, 8'h00);
        check_output({tag, "_dp_a"},   {7'b0, dp_a},   8'h00);
        check_output({tag, "_an_a"},   {4'b0, an_a},   8'h00);
        check_output({tag, "_disp_b"}, {1'b0, disp_b}, 8'h7F);
        check_output({tag, "_dp_b"},   {7'b0, dp_b},   8'h01);
        check_output({tag, "_an_b"},   {4'b0, an_b},   8'h0F);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp = '0; lz = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        cmp_on = 1'b1;
        check_inactive("reset");
        rst_n = 1'b1;

        // Scan order: 0x1234 loaded while stopped, then scanning starts.
        apply_stimulus(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k <= 16; k++) begin
            apply_stimulus(1'b1, 1'b0, 16'h1234, 4'b0000, 1'b0);
            check_output("scan_an",   {4'b0, an_a},   {4'b0, lit_an[2'((k / 4) % 4)]});
            check_output("scan_disp", {1'b0, disp_a}, {1'b0, lit_scan[2'((k / 4) % 4)]});
        end

        // No tearing: 0x5678 arrives while digit 1 is on.
        run_idle(3);
        apply_stimulus(1'b1, 1'b1, 16'h5678, 4'b0000, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h5678, 4'b0000, 1'b0);
        check_output("tear_d1", {1'b0, disp_a}, 8'b0111_1001);
        run_idle(3);
        check_output("tear_d2", {1'b0, disp_a}, 8'b0110_1101);
        run_idle(4);
        check_output("tear_d3", {1'b0, disp_a}, 8'b0011_0000);
        run_idle(4);
        check_output("tear_new_d0", {1'b0, disp_a}, 8'b0111_1111);
        check_output("tear_new_an", {4'b0, an_a},   8'b0000_0001);

        // Load on the wrap edge itself, with an E in digit 0.
        run_idle(14);
        apply_stimulus(1'b1, 1'b1, 16'h123E, 4'b0001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h123E, 4'b0001, 1'b0);
        check_output("wrapload_hex_e",  {1'b0, disp_a}, 8'b0100_1111);
        check_output("wrapload_dec_e",  {1'b0, disp_b}, 8'b0111_1111);
        check_output("wrapload_dp",     {7'b0, dp_a},   8'h01);
        check_output("wrapload_an",     {4'b0, an_a},   8'h01);

        // Leading-zero suppression of 0x0040.
        apply_stimulus(1'b0, 1'b1, 16'h0040, 4'b0000, 1'b1);
        check_output("stop_an", {4'b0, an_a}, 8'h00);
        apply_stimulus(1'b1, 1'b0, 16'h0040, 4'b0000, 1'b1);
        check_output("lz_d0", {1'b0, disp_a}, 8'b0111_1110);
        run_idle(4);
        check_output("lz_d1", {1'b0, disp_a}, 8'b0011_0011);
        run_idle(4);
        check_output("lz_d2", {1'b0, disp_a}, 8'h00);
        check_output("lz_d2_an", {4'b0, an_a}, 8'b0000_0100);
        run_idle(4);
        check_output("lz_d3", {1'b0, disp_a}, 8'h00);

        // All zeros with suppression: only digit 0 lit; also the inverted view.
        apply_stimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1);
        apply_stimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1);
        check_output("zero_d0",     {1'b0, disp_a}, 8'b0111_1110);
        check_output("zero_d0_inv", {1'b0, disp_b}, 8'b0000_0001);
        check_output("zero_an_inv", {4'b0, an_b},   8'b0000_1110);
        run_idle(4);
        check_output("zero_d1", {1'b0, disp_a}, 8'h00);

        // Reset pulse mid-frame with a load still pending.
        apply_stimulus(1'b1, 1'b1, 16'h7777, 4'b1111, 1'b0);
        run_idle(1);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check_inactive("pulse");
        apply_stimulus(1'b1, 1'b0, 16'h7777, 4'b1111, 1'b0);
        check_output("pulse_an",   {4'b0, an_a},   8'h01);
        check_output("pulse_disp", {1'b0, disp_a}, 8'b0111_1110);
        run_idle(20);
        check_output("pulse_discard_disp", {1'b0, disp_a}, 8'b0111_1110);
        check_output("pulse_discard_dp",   {7'b0, dp_a},   8'h00);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: rnd_value = 16'($urandom);
                1: rnd_value = 16'($urandom_range(0, 255));
                2: rnd_value = 16'($urandom_range(0, 15));
                default: rnd_value = 16'h0000;
            endcase
            apply_stimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
                           rnd_value, 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DIGITS, 4, number of multiplexed digits, 1..8.
- SCAN_DIV, 50000, CLK cycles per digit slot, at least 2.
- HEX_MODE, 1, 1 means codes 10..15 show A..F; 0 means codes 10..15 are blank.
- SEG_ACTIVE_LOW, 0, 1 inverts DISP and DP_OUT at the output.
- AN_ACTIVE_LOW, 0, 1 inverts AN at the output.

REQ-002 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  scan enable.
- LOAD  in  1  one-cycle pulse that samples VALUE, DP and LZ.
- VALUE  in  4*DIGITS  BCD/hex nibbles; nibble i is digit i, and digit 0 is least significant.
- DP  in  DIGITS  decimal point per digit.
- LZ  in  1  leading-zero suppression enable.
- DISP  out  7  segments; DISP[6]=a down to DISP[0]=g.
- DP_OUT  out  1  decimal-point segment.
- AN  out  DIGITS  one-hot digit select.

Function
REQ-003 A prescaler SHALL count 0..SCAN_DIV-1 while EN=1 and wrap to 0; "tick" is defined as prescaler==SCAN_DIV-1.
- REQ-004 A digit index IDX SHALL advance on each tick, 0,1,...,DIGITS-1,0, wrapping with no idle slot.
- REQ-005 On LOAD=1, a staging register SHALL capture VALUE, DP and LZ, and a pending flag SHALL be set.
- REQ-006 When a tick wraps IDX from DIGITS-1 to 0 and pending=1, the shadow register SHALL take the staging contents and pending SHALL clear. No mid-frame tearing.
- REQ-007 When LOAD coincides with a wrapping tick, the VALUE/DP/LZ present that cycle SHALL go to both staging and shadow, and pending SHALL end 0.
- REQ-008 A LOAD while pending=1 SHALL overwrite staging; only the last load before the wrap is displayed.
- REQ-009 DISP, DP_OUT and AN SHALL be registered.
  - They reflect IDX and the shadow register with exactly 1 CLK latency after IDX changes.
  - The AN bit for IDX is active and all other AN bits are inactive.
- REQ-010 Segment codes, active-high before polarity inversion:
  - Decimal: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Hex (HEX_MODE=1): A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - HEX_MODE=0: codes 10..15 give 0000000.
- REQ-011 With shadow LZ=1, digit i SHALL be blanked (DISP=0000000, AN still driven) when nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - DP_OUT is unaffected by blanking.
- REQ-012 DP_OUT SHALL equal shadow DP[IDX].
- REQ-013 While EN=0, prescaler and IDX SHALL hold at 0, and the registered outputs SHALL go to inactive levels on the next edge.
  - LOAD is still accepted.
  - pending is applied to shadow directly on any cycle with EN=0.
- REQ-014 After EN rises, digit 0 SHALL be selected 1 cycle later, and the first tick SHALL occur SCAN_DIV cycles after EN rises.
- REQ-015 Polarity inversion SHALL apply after all logic and SHALL NOT affect timing.

Reset
REQ-016 RST=0 SHALL immediately, without waiting for a clock edge, clear prescaler, IDX, staging, shadow and pending to 0.
REQ-017 During reset, DISP=0000000, DP_OUT=0 and AN=all-inactive SHALL hold at the post-inversion inactive levels:
- All ones when the corresponding *_ACTIVE_LOW parameter is 1.
- All zeros otherwise.

REQ-018 Reset asserted mid-frame or mid-pending SHALL discard the pending load.

REQ-019 The first rising CLK edge after RST rises with EN=1 SHALL behave as the edge after EN rises (REQ-014).

Verification
REQ-020 Scan order: DIGITS=4, SCAN_DIV=4, EN=1, LOAD VALUE=0x1234 during reset release.
- AN sequence: 0001 (4 cycles), 0010, 0100, 1000, 0001.
- DISP per slot: 0110011, 1111001, 1101101, 0110000.

REQ-021 No tearing: shadow shows 0x1234; LOAD 0x5678 while IDX=1.
- Digits 1..3 still show 3,2,1.
- After the wrap, digit 0 shows 8 (1111111).

REQ-022 Leading-zero suppression: LOAD 0x0040 with LZ=1.
- Digits 3 and 2 give DISP=0000000.
- Digit 1 gives 0110011; digit 0 gives 1111110.
- LOAD 0x0000 shows only digit 0 lit, as 1111110.

REQ-023 Hex mode: HEX_MODE=1 with nibble 0xE shows 1001111; HEX_MODE=0 with the same nibble shows 0000000.

REQ-024 Polarity: SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, digit 0 value 0.
- DISP=0000001 and AN=1110.
- During reset: DISP=1111111, DP_OUT=1, AN=1111.

REQ-025 Edge cases:
- RST pulsed low for 1 ns mid-frame: outputs go inactive immediately and IDX=0 after release.
- LOAD on the same edge as the wrap: the new value appears in the very next digit-0 slot.
